// File: rtl/mips_enc_if.sv
// Command bus carrying MIPS instruction field commands into mips_inst_encoder.
interface mips_enc_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [4:0]  cmd_class;
    logic [4:0]  cmd_rs;
    logic [4:0]  cmd_rt;
    logic [4:0]  cmd_rd;
    logic [4:0]  cmd_shamt;
    logic [25:0] cmd_imm;
    logic        cmd_last;

    modport master (
        output cmd_valid, cmd_class, cmd_rs, cmd_rt, cmd_rd, cmd_shamt, cmd_imm, cmd_last,
        input  cmd_ready
    );
    modport slave (
        input  cmd_valid, cmd_class, cmd_rs, cmd_rt, cmd_rd, cmd_shamt, cmd_imm, cmd_last,
        output cmd_ready
    );
endinterface

// File: rtl/mips_inst_encoder.sv
// Encodes instruction field commands into MIPS words, buffers them and writes them into imem.
// Optional ENC_CHECK_EN: reject class > 22 and raise a sticky err flag.
module mips_inst_encoder #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    mips_enc_if.slave         cmd,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_e;

    state_e            state_q, state_d;
    logic [31:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d, imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic              imem_we_q, imem_we_d, cmd_ready_q, cmd_ready_d;
    logic              busy_q, busy_d, done_q, done_d, err_q, err_d;

    logic [31:0]       enc_word_c;
    logic [14:0]       rregs_c;
    logic [25:0]       ibody_c;
    logic              accept_c, push_c, pop_c, bypass_c, store_c;

    assign rregs_c  = {cmd.cmd_rs, cmd.cmd_rt, cmd.cmd_rd};
    assign ibody_c  = {cmd.cmd_rs, cmd.cmd_rt, cmd.cmd_imm[15:0]};
    assign accept_c = cmd.cmd_valid & cmd_ready_q;

`ifdef ENC_CHECK_EN
    logic enc_legal_c;
    assign enc_legal_c = (cmd.cmd_class <= 5'd22);
    assign push_c      = accept_c & enc_legal_c;
`else
    assign push_c      = accept_c;
`endif

    // A word entering an empty buffer goes straight to the imem port for one-cycle latency.
    assign pop_c    = ((state_q == LOAD) || (state_q == DRAIN)) && (count_q != '0);
    assign bypass_c = push_c && (count_q == '0);
    assign store_c  = push_c && !bypass_c;

    // Field command to 32-bit instruction word.
    always_comb begin
        enc_word_c = 32'h0;
        case (cmd.cmd_class)
            5'd0:    enc_word_c = {6'h00, rregs_c, 5'd0, 6'h20};
            5'd1:    enc_word_c = {6'h00, rregs_c, 5'd0, 6'h22};
            5'd2:    enc_word_c = {6'h00, rregs_c, 5'd0, 6'h24};
            5'd3:    enc_word_c = {6'h00, rregs_c, 5'd0, 6'h25};
            5'd4:    enc_word_c = {6'h00, rregs_c, 5'd0, 6'h27};
            5'd5:    enc_word_c = {6'h00, rregs_c, 5'd0, 6'h2A};
            5'd6:    enc_word_c = {6'h00, rregs_c, cmd.cmd_shamt, 6'h00};
            5'd7:    enc_word_c = {6'h00, rregs_c, cmd.cmd_shamt, 6'h02};
            5'd8:    enc_word_c = {6'h00, rregs_c, cmd.cmd_shamt, 6'h03};
            5'd9:    enc_word_c = {6'h00, rregs_c, 5'd0, 6'h07};
            5'd10:   enc_word_c = {6'h00, cmd.cmd_rs, 10'd0, 5'd0, 6'h08};
            5'd11:   enc_word_c = {6'h08, ibody_c};
            5'd12:   enc_word_c = {6'h0C, ibody_c};
            5'd13:   enc_word_c = {6'h0D, ibody_c};
            5'd14:   enc_word_c = {6'h0A, ibody_c};
            5'd15:   enc_word_c = {6'h23, ibody_c};
            5'd16:   enc_word_c = {6'h2B, ibody_c};
            5'd17:   enc_word_c = {6'h21, ibody_c};
            5'd18:   enc_word_c = {6'h04, ibody_c};
            5'd19:   enc_word_c = {6'h05, ibody_c};
            5'd20:   enc_word_c = {6'h01, cmd.cmd_rs, 5'd0, cmd.cmd_imm[15:0]};
            5'd21:   enc_word_c = {6'h02, cmd.cmd_imm};
            5'd22:   enc_word_c = {6'h03, cmd.cmd_imm};
            default: enc_word_c = 32'h0;
        endcase
    end

    // Next-state, buffer bookkeeping and registered output values.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q + CNT_W'(store_c) - CNT_W'(pop_c);
        ptr_d        = ptr_q;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        imem_we_d    = pop_c | bypass_c;
        err_d        = err_q;

        if (pop_c) begin
            imem_wdata_d = mem_q[rd_ptr_q];
            rd_ptr_d     = rd_ptr_q + PTR_W'(1);
        end else if (bypass_c) begin
            imem_wdata_d = enc_word_c;
        end
        if (imem_we_d) begin
            imem_addr_d = ptr_q;
            ptr_d       = ptr_q + ADDR_W'(1);
        end
        if (store_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
`ifdef ENC_CHECK_EN
        if (accept_c && !enc_legal_c) begin
            err_d = 1'b1;
        end
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = LOAD;
                    ptr_d       = ADDR_W'(BASE_ADDR);
                    imem_addr_d = ADDR_W'(BASE_ADDR);
                    err_d       = 1'b0;
                end
            end
            LOAD:    if (accept_c && cmd.cmd_last) state_d = DRAIN;
            DRAIN:   if (count_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        cmd_ready_d = (state_d == LOAD) && (count_d < CNT_W'(FIFO_DEPTH));
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ptr_q        <= ADDR_W'(BASE_ADDR);
            imem_addr_q  <= ADDR_W'(BASE_ADDR);
            imem_wdata_q <= 32'h0;
            imem_we_q    <= 1'b0;
            cmd_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            ptr_q        <= ptr_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            imem_we_q    <= imem_we_d;
            cmd_ready_q  <= cmd_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    // Buffer storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (store_c) begin
            mem_q[wr_ptr_q] <= enc_word_c;
        end
    end

    assign cmd.cmd_ready = cmd_ready_q;
    assign imem_we       = imem_we_q;
    assign imem_addr     = imem_addr_q;
    assign imem_wdata    = imem_wdata_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
endmodule

// File: tb/tb_mips_inst_encoder.sv
// Self-checking bench for mips_inst_encoder: directed vectors plus random programs vs a reference model.
`timescale 1ns/1ps
module tb_mips_inst_encoder;
    localparam int unsigned ADDR_W    = 10;
    localparam int unsigned MEM_WORDS = 1 << ADDR_W;
    localparam int unsigned FUNC_TAB [11] = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h27, 32'h2A,
                                              32'h00, 32'h02, 32'h03, 32'h07, 32'h08};
    localparam int unsigned OP_TAB [10]   = '{32'h08, 32'h0C, 32'h0D, 32'h0A, 32'h23, 32'h2B,
                                              32'h21, 32'h04, 32'h05, 32'h01};

    logic              clk = 1'b0;
    logic              rst, start;
    logic              imem_we, busy, done, err;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    mips_enc_if ifc ();

    mips_inst_encoder #(.FIFO_DEPTH(4), .ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .start(start), .cmd(ifc.slave),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0, n_fail = 0, stalls = 0, model_ptr = 0, done_cnt = 0;
    int unsigned exp_addr[$], obs_addr[$];
    logic [31:0] exp_data[$], obs_data[$];

    always @(negedge clk) begin
        if (imem_we) begin
            obs_addr.push_back(int'(imem_addr));
            obs_data.push_back(imem_wdata);
        end
        if (done) done_cnt++;
    end

    // Reference encoding from the instruction-format rules.
    function automatic logic [31:0] ref_encode(int unsigned cls, int unsigned rs, int unsigned rt,
                                               int unsigned rd, int unsigned sh, int unsigned imm);
        if (cls <= 10) begin
            if (cls == 10) begin rt = 0; rd = 0; end
            if (cls < 6 || cls > 8) sh = 0;
            return (rs << 21) + (rt << 16) + (rd << 11) + (sh << 6) + FUNC_TAB[cls];
        end
        if (cls <= 20) begin
            if (cls == 20) rt = 0;
            return (OP_TAB[cls-11] << 26) + (rs << 21) + (rt << 16) + (imm % 65536);
        end
        if (cls <= 22) return ((cls - 19) << 26) + (imm % (1 << 26));
        return 0;
    endfunction

    task automatic clear();
        exp_addr.delete(); exp_data.delete(); obs_addr.delete(); obs_data.delete();
        stalls = 0;
    endtask

    task automatic pulse_start(input bit restart_model);
        @(negedge clk);
        start = 1'b1;
        if (restart_model) model_ptr = 0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input int unsigned cls, input int unsigned rs, input int unsigned rt,
                        input int unsigned rd, input int unsigned sh, input int unsigned imm,
                        input bit last);
        bit ok = 1'b0;
        bit legal;
        @(negedge clk);
        ifc.cmd_valid = 1'b1;   ifc.cmd_class = 5'(cls); ifc.cmd_rs = 5'(rs);
        ifc.cmd_rt    = 5'(rt); ifc.cmd_rd    = 5'(rd);  ifc.cmd_shamt = 5'(sh);
        ifc.cmd_imm   = 26'(imm); ifc.cmd_last = last;
        for (int i = 0; i < 20; i++) begin
            if (ifc.cmd_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
`ifdef ENC_CHECK_EN
        legal = (cls <= 22);
`else
        legal = 1'b1;
`endif
        if (ok) begin
            @(posedge clk);
            if (legal) begin
                exp_addr.push_back(model_ptr);
                exp_data.push_back(ref_encode(cls, rs, rt, rd, sh, imm));
                model_ptr = (model_ptr + 1) % MEM_WORDS;
            end
        end else begin
            stalls++;
        end
        #1;
        ifc.cmd_valid = 1'b0;
        ifc.cmd_last  = 1'b0;
    endtask

    task automatic send_rand(input int unsigned max_cls, input bit last);
        send($urandom_range(0, max_cls), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 31), $urandom, last);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        stalls++;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        ifc.cmd_valid = 1'b0; ifc.cmd_class = '0; ifc.cmd_rs = '0; ifc.cmd_rt = '0;
        ifc.cmd_rd = '0; ifc.cmd_shamt = '0; ifc.cmd_imm = '0; ifc.cmd_last = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({imem_we, busy, done, err, ifc.cmd_ready} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b required 00000", {imem_we, busy, done, err, ifc.cmd_ready});
        end
        n_checks++;
        if (imem_addr !== '0 || imem_wdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_bus: got addr %0d data %h required 0/0", imem_addr, imem_wdata);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || ifc.cmd_ready !== 1'b0) begin
            n_fail++; $display("FAIL idle_after_reset: got busy %b ready %b required 0 0", busy, ifc.cmd_ready);
        end
    endtask

    task automatic test_directed();
        int unsigned d0;
        clear(); d0 = done_cnt;
        pulse_start(1'b1);
        send(0, 1, 2, 3, 0, 0, 1'b1);
        wait_idle();
        n_checks++;
        if (obs_data.size() !== 1 || obs_addr[0] !== 0 || obs_data[0] !== 32'h0022_1820) begin
            n_fail++; $display("FAIL add_vector: got n=%0d addr %0d data %h required 1 word @0 00221820",
                               obs_data.size(), obs_addr[0], obs_data[0]);
        end
        n_checks++;
        if (done_cnt - d0 !== 1) begin
            n_fail++; $display("FAIL done_pulse: got %0d pulses required 1", done_cnt - d0);
        end
        clear(); d0 = done_cnt;
        pulse_start(1'b1);
        send(15, 29, 8, 0, 0, 32'h0010, 1'b0);
        send(21, 0, 0, 0, 0, 32'h40, 1'b1);
        wait_idle();
        n_checks++;
        if (obs_data.size() !== 2 || obs_data[0] !== 32'h8FA8_0010 || obs_data[1] !== 32'h0800_0040 ||
            obs_addr[0] !== 0 || obs_addr[1] !== 1) begin
            n_fail++; $display("FAIL lw_j_vector: got n=%0d %h@%0d %h@%0d required 8fa80010@0 08000040@1",
                               obs_data.size(), obs_data[0], obs_addr[0], obs_data[1], obs_addr[1]);
        end
        n_checks++;
        if (done_cnt - d0 !== 1) begin
            n_fail++; $display("FAIL done_pulse_2: got %0d pulses required 1", done_cnt - d0);
        end
        clear();
        pulse_start(1'b1);
        send(20, 4, 7, 0, 0, 32'hFFFE, 1'b0);
        send(6, 0, 2, 2, 4, 0, 1'b1);
        wait_idle();
        n_checks++;
        if (obs_data.size() !== 2 || obs_data[0] !== 32'h0480_FFFE || obs_data[1] !== 32'h0002_1100) begin
            n_fail++; $display("FAIL bltz_sll_vector: got n=%0d %h %h required 0480fffe 00021100",
                               obs_data.size(), obs_data[0], obs_data[1]);
        end
        n_checks++;
        if (stalls !== 0) begin
            n_fail++; $display("FAIL directed_stall: got %0d timeouts required 0", stalls);
        end
    endtask

    task automatic test_back_to_back();
        int unsigned n;
        clear();
        pulse_start(1'b1);
        for (int i = 0; i < 6; i++) send_rand(22, i == 5);
        wait_idle();
        n_checks++;
        if (obs_data.size() !== 6 || stalls !== 0) begin
            n_fail++; $display("FAIL b2b_count: got %0d words %0d timeouts required 6 and 0", obs_data.size(), stalls);
        end
        n = (obs_data.size() < exp_data.size()) ? obs_data.size() : exp_data.size();
        for (int i = 0; i < int'(n); i++) begin
            n_checks++;
            if (obs_addr[i] !== i || obs_data[i] !== exp_data[i]) begin
                n_fail++; $display("FAIL b2b_word[%0d]: got %h@%0d required %h@%0d",
                                   i, obs_data[i], obs_addr[i], exp_data[i], i);
            end
        end
    endtask

    task automatic test_random();
        int unsigned n, d0;
        clear(); d0 = done_cnt;
        for (int p = 0; p < 20; p++) begin
            int unsigned len = $urandom_range(1, 10);
            pulse_start(1'b1);
            for (int i = 0; i < int'(len); i++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send_rand(22, i == int'(len) - 1);
            end
            wait_idle();
        end
        n_checks++;
        if (obs_data.size() !== exp_data.size() || stalls !== 0 || done_cnt - d0 !== 20) begin
            n_fail++; $display("FAIL rand_count: got %0d words %0d timeouts %0d done required %0d words 0 timeouts 20 done",
                               obs_data.size(), stalls, done_cnt - d0, exp_data.size());
        end
        n = (obs_data.size() < exp_data.size()) ? obs_data.size() : exp_data.size();
        for (int i = 0; i < int'(n); i++) begin
            n_checks++;
            if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
                n_fail++; $display("FAIL rand_word[%0d]: got %h@%0d required %h@%0d",
                                   i, obs_data[i], obs_addr[i], exp_data[i], exp_addr[i]);
            end
        end
    endtask

    task automatic test_start_ignored();
        clear();
        pulse_start(1'b1);
        send_rand(22, 1'b0);
        send_rand(22, 1'b0);
        pulse_start(1'b0);
        send_rand(22, 1'b0);
        send_rand(22, 1'b1);
        wait_idle();
        n_checks++;
        if (obs_data.size() !== 4 || obs_addr[2] !== 2 || obs_addr[3] !== 3 || obs_data[3] !== exp_data[3]) begin
            n_fail++; $display("FAIL start_while_busy: got n=%0d addr2 %0d addr3 %0d data3 %h required 4 2 3 %h",
                               obs_data.size(), obs_addr[2], obs_addr[3], obs_data[3], exp_data[3]);
        end
    endtask

    task automatic test_wrap();
        int unsigned n, bad = 0;
        clear();
        pulse_start(1'b1);
        for (int i = 0; i < 1030; i++) send_rand(22, i == 1029);
        wait_idle();
        n_checks++;
        if (obs_data.size() !== 1030 || stalls !== 0) begin
            n_fail++; $display("FAIL wrap_count: got %0d words %0d timeouts required 1030 0", obs_data.size(), stalls);
        end
        n = (obs_data.size() < exp_data.size()) ? obs_data.size() : exp_data.size();
        for (int i = 0; i < int'(n); i++) begin
            n_checks++;
            if (obs_addr[i] !== (i % MEM_WORDS) || obs_data[i] !== exp_data[i]) begin
                n_fail++; bad++;
                if (bad < 8) $display("FAIL wrap_word[%0d]: got %h@%0d required %h@%0d",
                                      i, obs_data[i], obs_addr[i], exp_data[i], i % MEM_WORDS);
            end
        end
    endtask

    task automatic test_illegal();
        int unsigned d0;
        clear(); d0 = done_cnt;
        pulse_start(1'b1);
        send(31, 3, 3, 3, 3, 32'h1234, 1'b1);
        wait_idle();
`ifdef ENC_CHECK_EN
        n_checks++;
        if (obs_data.size() !== 0 || err !== 1'b1 || done_cnt - d0 !== 1) begin
            n_fail++; $display("FAIL illegal_reject: got n=%0d err %b done %0d required 0 1 1",
                               obs_data.size(), err, done_cnt - d0);
        end
        pulse_start(1'b1);
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++; $display("FAIL err_clear_on_start: got %b required 0", err);
        end
        send(0, 1, 1, 1, 0, 0, 1'b0);
        send(25, 1, 1, 1, 0, 0, 1'b0);
        send(1, 2, 2, 2, 0, 0, 1'b1);
        wait_idle();
        n_checks++;
        if (obs_data.size() !== 2 || obs_addr[1] !== 1 || obs_data[1] !== exp_data[1] || err !== 1'b1) begin
            n_fail++; $display("FAIL illegal_mid: got n=%0d addr1 %0d data1 %h err %b required 2 1 %h 1",
                               obs_data.size(), obs_addr[1], obs_data[1], err, exp_data[1]);
        end
`else
        n_checks++;
        if (obs_data.size() !== 1 || obs_addr[0] !== 0 || obs_data[0] !== 32'h0 || err !== 1'b0 || done_cnt - d0 !== 1) begin
            n_fail++; $display("FAIL illegal_nop: got n=%0d %h@%0d err %b done %0d required 1 00000000@0 0 1",
                               obs_data.size(), obs_data[0], obs_addr[0], err, done_cnt - d0);
        end
`endif
    endtask

    task automatic test_reset_mid();
        clear();
        pulse_start(1'b1);
        for (int i = 0; i < 3; i++) send_rand(22, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({imem_we, busy, done, ifc.cmd_ready} !== 4'b0 || imem_addr !== '0) begin
            n_fail++; $display("FAIL reset_mid: got we/busy/done/ready %b addr %0d required 0000 0",
                               {imem_we, busy, done, ifc.cmd_ready}, imem_addr);
        end
        rst = 1'b0;
        clear();
        pulse_start(1'b1);
        send(2, 5, 6, 7, 0, 0, 1'b1);
        wait_idle();
        n_checks++;
        if (obs_data.size() !== 1 || obs_addr[0] !== 0 || obs_data[0] !== exp_data[0]) begin
            n_fail++; $display("FAIL after_reset_mid: got n=%0d %h@%0d required 1 %h@0",
                               obs_data.size(), obs_data[0], obs_addr[0], exp_data[0]);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_start_ignored();
        test_illegal();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end
endmodule
